// File: rtl/slot_alloc_tracker.sv
// Occupancy tracker for a pool of WIDTH entry slots with REQS allocation ways per cycle.
// Optional macro SLOT_ALLOC_BYPASS_EN lets slots released this cycle be re-granted immediately.
module slot_alloc_tracker #(
  parameter int WIDTH = 16,
  parameter int REQS  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH*REQS-1:0]      alloc_gnt_bus,
  input  logic [REQS-1:0]            alloc_valid,
  input  logic [WIDTH-1:0]           release_vec,
  input  logic                       flush,
  output logic [WIDTH-1:0]           free_vec,
  output logic [WIDTH-1:0]           occupied,
  output logic [$clog2(WIDTH+1)-1:0] free_count,
  output logic [$clog2(REQS+1)-1:0]  avail_ways,
  output logic                       stall,
  output logic                       alloc_err
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int AW = $clog2(REQS+1);

  logic [WIDTH-1:0]            occupied_q, occupied_d;
  logic [CW-1:0]               free_count_q, free_count_d;
  logic                        alloc_err_q, alloc_err_d;
  logic [REQS-1:0][WIDTH-1:0]  way_gnt;
  logic [REQS-1:0]             way_bad;
  logic [WIDTH-1:0]            alloc_mask;
  logic [WIDTH-1:0]            overlap;
  logic [CW-1:0]               ones;

`ifdef SLOT_ALLOC_BYPASS_EN
  assign free_vec = ~occupied_q | release_vec;
`else
  assign free_vec = ~occupied_q;
`endif

  // Per-way qualification: invalid ways contribute nothing and cannot raise an error.
  for (genvar gi = 0; gi < REQS; gi++) begin : g_way
    logic [WIDTH-1:0] raw;
    logic             not_onehot;
    assign raw        = alloc_gnt_bus[(gi+1)*WIDTH-1 -: WIDTH];
    assign not_onehot = (raw == '0) || ((raw & (raw - WIDTH'(1))) != '0);
    assign way_gnt[gi] = alloc_valid[gi] ? raw : '0;
    assign way_bad[gi] = alloc_valid[gi] & (not_onehot | (|(raw & ~free_vec)));
  end

  always_comb begin
    alloc_mask = '0;
    overlap    = '0;
    for (int j = 0; j < REQS; j++) begin
      overlap    = overlap | (alloc_mask & way_gnt[j]);
      alloc_mask = alloc_mask | way_gnt[j];
    end

    // Allocation wins over release on the same slot; errors never roll state back.
    occupied_d = flush ? '0 : ((occupied_q & ~release_vec) | alloc_mask);

    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(occupied_d[i]);
    end
    free_count_d = CW'(WIDTH) - ones;

    alloc_err_d = alloc_err_q | (~flush & ((|way_bad) | (|overlap)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occupied_q   <= '0;
      free_count_q <= CW'(WIDTH);
      alloc_err_q  <= 1'b0;
    end else begin
      occupied_q   <= occupied_d;
      free_count_q <= free_count_d;
      alloc_err_q  <= alloc_err_d;
    end
  end

  assign occupied   = occupied_q;
  assign free_count = free_count_q;
  assign alloc_err  = alloc_err_q;
  assign avail_ways = (free_count_q >= CW'(REQS)) ? AW'(REQS) : AW'(free_count_q);
  assign stall      = (free_count_q < CW'(REQS));

endmodule

// File: doc/slot_alloc_tracker.md
SLOT_ALLOC_TRACKER -- requirements
Module: slot_alloc_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of tracked entry slots (>= 2).
REQ-002 SHALL have parameter REQS, default 2: number of allocation ways per cycle (1 <= REQS <= WIDTH).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port alloc_gnt_bus  input  WIDTH*REQS  per-way one-hot slot grant from the downstream priority selector; way j occupies bits [(j+1)*WIDTH-1 -: WIDTH].
REQ-006 SHALL have port alloc_valid  input  REQS  bit j set means way j allocates its granted slot this cycle.
REQ-007 SHALL have port release_vec  input  WIDTH  slots freed this cycle (issue/retire).
REQ-008 SHALL have port flush  input  1  frees every slot.
REQ-009 SHALL have port free_vec  output  WIDTH  free-slot request vector driven to the priority selector req input.
REQ-010 SHALL have port occupied  output  WIDTH  registered occupancy bitmap.
REQ-011 SHALL have port free_count  output  $clog2(WIDTH+1)  registered number of free slots.
REQ-012 SHALL have port avail_ways  output  $clog2(REQS+1)  min(free_count, REQS), combinational from registers.
REQ-013 SHALL have port stall  output  1  high when free_count < REQS.
REQ-014 SHALL have port alloc_err  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL form alloc_mask = OR over j of (alloc_gnt_bus way j AND alloc_valid[j] replicated); ways with alloc_valid low are ignored entirely.
REQ-016 SHALL update occupied_next = (occupied & ~release_vec) | alloc_mask each cycle; alloc takes priority over release on the same slot.
REQ-017 SHALL update free_count_next = WIDTH - popcount(occupied_next) on the same edge as occupied (free_count always consistent with occupied).
REQ-018 SHALL give occupied and free_count a 1-cycle latency: inputs in cycle N are visible at outputs in cycle N+1.
REQ-019 SHALL on flush=1 set occupied to 0 and free_count to WIDTH next cycle, ignoring alloc_mask and release_vec that cycle.
REQ-020 SHALL treat a release of an already-free slot as a no-op, without error.
REQ-021 SHALL set alloc_err (when flush=0) if any valid way grant is not exactly one-hot, if two valid ways grant the same slot, or if a valid way grants a slot not currently in free_vec.
REQ-022 SHALL hold alloc_err high once set, until reset; flush does not clear it.
REQ-023 SHALL still apply REQ-016 on an erroneous cycle (no state rollback).
REQ-024 SHALL keep stall and avail_ways purely a function of registered free_count (no combinational path from alloc inputs).

Reset
REQ-025 SHALL on reset=1 at a rising edge set occupied=0, free_count=WIDTH, alloc_err=0; hence free_vec=all ones, avail_ways=REQS, stall=0.
REQ-026 SHALL give reset priority over flush, allocation and release, including mid-operation.

Configuration
REQ-027 SHALL support macro SLOT_ALLOC_BYPASS_EN.
REQ-028 SHALL with SLOT_ALLOC_BYPASS_EN defined drive free_vec = ~occupied | release_vec, so same-cycle released slots are grantable; allocating such a slot is legal.
REQ-029 SHALL without SLOT_ALLOC_BYPASS_EN drive free_vec = ~occupied (registered only); allocating a slot being released that cycle sets alloc_err.
REQ-030 SHALL keep free_count, avail_ways and stall registered-only in both builds.

Verification (WIDTH=8, REQS=2)
REQ-031 SHALL cover reset: after reset -> occupied=8'h00, free_count=8, free_vec=8'hFF, avail_ways=2, stall=0, alloc_err=0.
REQ-032 SHALL cover dual alloc: way0 grant 8'h80, way1 grant 8'h40, alloc_valid=2'b11 -> next cycle occupied=8'hC0, free_count=6.
REQ-033 SHALL cover fill to stall: allocate until occupied=8'hFE -> free_count=1, avail_ways=1, stall=1; then release_vec=8'h02 -> occupied=8'hFC, free_count=2, stall=0.
REQ-034 SHALL cover error: occupied=8'h80, way0 grant 8'h80 valid -> alloc_err=1 and remains 1 after flush; grant 8'h03 valid -> alloc_err=1.
REQ-035 SHALL cover bypass: occupied=8'hFF, release_vec=8'h01, way0 grant 8'h01 valid -> bypass build: alloc_err=0, occupied=8'hFF; non-bypass build: alloc_err=1.
REQ-036 SHALL cover flush and reset collision: flush=1 with alloc -> occupied=8'h00, free_count=8; reset=1 with flush and alloc -> full reset state.
